// File: rtl/shift_serializer.sv
// shift_serializer: parallel-to-serial converter with load/ready handshake,
// shift stall, and a one-cycle done pulse after the final bit of each word.
//
// Ports
//   clock       rising-edge clock
//   _reset      synchronous active-low reset
//   d           parallel word to serialize (WIDTH bits)
//   load_valid  upstream has a word on d
//   load_ready  block is idle and will accept a word on the next edge
//   hold        freezes shifting while in SHIFT (no effect when idle)
//   q           serial data bit (0 when idle)
//   nq          complement of q
//   q_valid     q carries a data bit
//   done        single-cycle pulse in the cycle after the final shift
module shift_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             _reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             q,
  output logic             nq,
  output logic             q_valid,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;

  // Shift toward the output end with zero fill.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};
  assign out_bit       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  // State, shift register, bit counter and done flag.
  always_ff @(posedge clock) begin
    if (!_reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= d;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!hold) begin
            shreg <= shreg_shifted;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  assign load_ready = (state == IDLE);
  assign q_valid    = (state == SHIFT);
  assign q          = (state == SHIFT) ? out_bit : 1'b0;
  assign nq         = ~q;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed testbench for shift_serializer. Two instances share stimulus:
// u_lsb (MSB_FIRST=0) and u_msb (MSB_FIRST=1), both WIDTH=8.
module tb_shift_serializer;

  logic       clock;
  logic       _reset;
  logic [7:0] d;
  logic       load_valid;
  logic       hold;

  logic l_ready, l_q, l_nq, l_valid, l_done;
  logic m_ready, m_q, m_nq, m_valid, m_done;

  int tests;
  int fails;

  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), ._reset(_reset), .d(d), .load_valid(load_valid),
    .load_ready(l_ready), .hold(hold), .q(l_q), .nq(l_nq),
    .q_valid(l_valid), .done(l_done)
  );

  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), ._reset(_reset), .d(d), .load_valid(load_valid),
    .load_ready(m_ready), .hold(hold), .q(m_q), .nq(m_nq),
    .q_valid(m_valid), .done(m_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one clock edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    _reset = 1'b0; load_valid = 1'b1; hold = 1'b0; d = 8'hFF;
    step();
    step();
    tests++;
    if ({l_q, l_nq, l_valid, l_ready, l_done} !== 5'b01010) begin
      fails++;
      $display("FAIL reset_lsb: got q,nq,valid,ready,done=%b expected 01010",
               {l_q, l_nq, l_valid, l_ready, l_done});
    end
    tests++;
    if ({m_q, m_nq, m_valid, m_ready, m_done} !== 5'b01010) begin
      fails++;
      $display("FAIL reset_msb: got q,nq,valid,ready,done=%b expected 01010",
               {m_q, m_nq, m_valid, m_ready, m_done});
    end
    load_valid = 1'b0;
    _reset = 1'b1;
    step();
    tests++;
    if ({l_valid, l_ready, l_done} !== 3'b010) begin
      fails++;
      $display("FAIL reset_idle: got valid,ready,done=%b expected 010",
               {l_valid, l_ready, l_done});
    end
  endtask

  // 8'h1E LSB first -> 0,1,1,1,1,0,0,0
  task automatic test_lsb_first();
    logic [7:0] seq;
    seq = 8'b0001_1110;  // seq[i] = expected q in cycle i+1
    d = 8'h1E; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if ({l_q, l_nq, l_valid, l_ready, l_done} !== {seq[c-1], ~seq[c-1], 3'b100}) begin
        fails++;
        $display("FAIL lsb_cycle%0d: got q,nq,valid,ready,done=%b expected %b",
                 c, {l_q, l_nq, l_valid, l_ready, l_done},
                 {seq[c-1], ~seq[c-1], 3'b100});
      end
      step();
    end
    tests++;
    if ({l_valid, l_ready, l_done, l_q} !== 4'b0110) begin
      fails++;
      $display("FAIL lsb_done9: got valid,ready,done,q=%b expected 0110",
               {l_valid, l_ready, l_done, l_q});
    end
    step();
    tests++;
    if (l_done !== 1'b0) begin
      fails++;
      $display("FAIL lsb_done_pulse: got done=%b expected 0", l_done);
    end
  endtask

  // 8'h1E MSB first -> 0,0,0,1,1,1,1,0; loaded with hold=1 in IDLE.
  task automatic test_msb_first();
    logic [7:0] seq;
    seq = 8'b0111_1000;  // seq[i] = expected q in cycle i+1
    d = 8'h1E; load_valid = 1'b1; hold = 1'b1;
    step();
    load_valid = 1'b0; hold = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if ({m_q, m_nq, m_valid, m_done} !== {seq[c-1], ~seq[c-1], 2'b10}) begin
        fails++;
        $display("FAIL msb_cycle%0d: got q,nq,valid,done=%b expected %b",
                 c, {m_q, m_nq, m_valid, m_done}, {seq[c-1], ~seq[c-1], 2'b10});
      end
      step();
    end
    tests++;
    if ({m_valid, m_done} !== 2'b01) begin
      fails++;
      $display("FAIL msb_done9: got valid,done=%b expected 01", {m_valid, m_done});
    end
    step();
  endtask

  // 8'hFF with hold high in cycles 3..5 -> 11 valid cycles, done in cycle 12.
  task automatic test_hold();
    d = 8'hFF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tests++;
      if ({l_q, l_valid, l_done} !== 3'b110) begin
        fails++;
        $display("FAIL hold_cycle%0d: got q,valid,done=%b expected 110",
                 c, {l_q, l_valid, l_done});
      end
      hold = (c >= 3 && c <= 5);
      step();
    end
    hold = 1'b0;
    tests++;
    if ({l_valid, l_done} !== 2'b01) begin
      fails++;
      $display("FAIL hold_done12: got valid,done=%b expected 01", {l_valid, l_done});
    end
    step();
  endtask

  // load_valid held: 8'h01 then 8'h80, one gap cycle (cycle 9) between words.
  task automatic test_back_to_back();
    logic exp_q, exp_v, exp_done;
    d = 8'h01; load_valid = 1'b1;
    step();
    d = 8'h80;
    for (int c = 1; c <= 17; c++) begin
      exp_v    = (c != 9);
      exp_done = (c == 9);
      exp_q    = (c == 1) || (c == 17);
      tests++;
      if ({l_q, l_valid, l_done, l_ready} !== {exp_q, exp_v, exp_done, ~exp_v}) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got q,valid,done,ready=%b expected %b",
                 c, {l_q, l_valid, l_done, l_ready}, {exp_q, exp_v, exp_done, ~exp_v});
      end
      if (c == 10) load_valid = 1'b0;
      step();
    end
    tests++;
    if ({l_valid, l_done} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_done18: got valid,done=%b expected 01", {l_valid, l_done});
    end
    step();
  endtask

  // Reset during bit 4 of 8'hAA aborts the word with no done pulse.
  task automatic test_reset_abort();
    logic [7:0] seq;
    seq = 8'b1010_1010;
    d = 8'hAA; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tests++;
      if ({l_q, l_valid} !== {seq[c-1], 1'b1}) begin
        fails++;
        $display("FAIL abort_cycle%0d: got q,valid=%b expected %b",
                 c, {l_q, l_valid}, {seq[c-1], 1'b1});
      end
    end_step: step();
    end
    // Reset also overrides load_valid and hold.
    _reset = 1'b0; load_valid = 1'b1; hold = 1'b1;
    step();
    tests++;
    if ({l_q, l_nq, l_valid, l_ready, l_done} !== 5'b01010) begin
      fails++;
      $display("FAIL abort_reset: got q,nq,valid,ready,done=%b expected 01010",
               {l_q, l_nq, l_valid, l_ready, l_done});
    end
    _reset = 1'b1; load_valid = 1'b0; hold = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      tests++;
      if ({l_done, l_valid} !== 2'b00) begin
        fails++;
        $display("FAIL abort_no_done%0d: got done,valid=%b expected 00",
                 c, {l_done, l_valid});
      end
    end
  endtask

  // d changes and load_valid pulses mid-word; output still follows 8'hC5.
  task automatic test_ignore_midword();
    logic [7:0] seq;
    seq = 8'b1100_0101;  // LSB-first order of 8'hC5: 1,0,1,0,0,0,1,1
    d = 8'hC5; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if ({l_q, l_valid} !== {seq[c-1], 1'b1}) begin
        fails++;
        $display("FAIL midword_cycle%0d: got q,valid=%b expected %b",
                 c, {l_q, l_valid}, {seq[c-1], 1'b1});
      end
      if (c == 3) begin d = 8'h3A; load_valid = 1'b1; end
      if (c == 4) load_valid = 1'b0;
      step();
    end
    tests++;
    if ({l_valid, l_done} !== 2'b01) begin
      fails++;
      $display("FAIL midword_done9: got valid,done=%b expected 01", {l_valid, l_done});
    end
    step();
    tests++;
    if ({l_valid, l_done} !== 2'b00) begin
      fails++;
      $display("FAIL midword_idle: got valid,done=%b expected 00", {l_valid, l_done});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    _reset = 1'b0; d = '0; load_valid = 1'b0; hold = 1'b0;
    #1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_ignore_midword();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
